hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: per-stage Tnew scoreboard, youngest-match forwarding select,
// Tuse/Tnew data stall, and a multiply/divide busy counter that stalls HI/LO users.
module hazard_unit #(
    parameter int NSTG     = 3,
    parameter int TW       = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [4:0]                   d_rs,
    input  logic [4:0]                   d_rt,
    input  logic [TW-1:0]                d_rsTuse,
    input  logic [TW-1:0]                d_rtTuse,
    input  logic [4:0]                   d_a3,
    input  logic                         d_rfen,
    input  logic [TW-1:0]                d_tnew,
    input  logic                         d_mdstart,
    input  logic                         d_mdop,
    input  logic                         d_mduse,
    output logic                         stall,
    output logic [$clog2(NSTG+1)-1:0]    fwd_rs_sel,
    output logic [$clog2(NSTG+1)-1:0]    fwd_rt_sel,
    output logic                         md_busy
);

    localparam int SW = $clog2(NSTG+1);
    localparam int CW = $clog2(DIV_LAT+1);

    logic [NSTG:1][4:0]    r_a3;
    logic [NSTG:1][TW-1:0] r_tnew;
    logic [NSTG:1]         r_wen;
    logic [CW-1:0]         r_md_cnt;

    logic [1:0][4:0]       w_src;
    logic [1:0][TW-1:0]    w_tuse;
    logic [1:0]            w_hit;
    logic [1:0][SW-1:0]    w_hit_k;
    logic [1:0][TW-1:0]    w_hit_tnew;
    logic [1:0]            w_data_stall;
    logic [1:0][SW-1:0]    w_sel;
    logic                  w_md_busy;
    logic                  w_md_stall;
    logic                  w_stall;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // Scan oldest to youngest so the youngest matching stage overwrites older ones.
    always_comb begin
        w_src        = '0;
        w_tuse       = '0;
        w_hit        = '0;
        w_hit_k      = '0;
        w_hit_tnew   = '0;
        w_data_stall = '0;
        w_sel        = '0;
        w_src[0]     = d_rs;
        w_src[1]     = d_rt;
        w_tuse[0]    = d_rsTuse;
        w_tuse[1]    = d_rtTuse;
        for (int unsigned s = 0; s < 2; s++) begin
            for (int unsigned k = NSTG; k >= 1; k--) begin
                if (r_wen[k] && (r_a3[k] == w_src[s]) && (w_src[s] != 5'd0)) begin
                    w_hit[s]      = 1'b1;
                    w_hit_k[s]    = SW'(k);
                    w_hit_tnew[s] = r_tnew[k];
                end
            end
            w_data_stall[s] = w_hit[s] && (w_hit_tnew[s] > w_tuse[s]);
            w_sel[s]        = (w_hit[s] && (w_hit_tnew[s] == '0)) ? w_hit_k[s] : '0;
        end
    end

    assign w_md_busy  = (r_md_cnt != '0);
    assign w_md_stall = d_mduse && w_md_busy;
    assign w_stall    = (|w_data_stall) || w_md_stall;

    assign stall      = w_stall;
    assign fwd_rs_sel = w_sel[0];
    assign fwd_rt_sel = w_sel[1];
    assign md_busy    = w_md_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a3   <= '0;
            r_tnew <= '0;
            r_wen  <= '0;
        end else begin
            if (w_stall) begin
                r_a3[1]   <= '0;
                r_tnew[1] <= '0;
                r_wen[1]  <= 1'b0;
            end else begin
                r_a3[1]   <= d_a3;
                r_tnew[1] <= sat_dec(d_tnew);
                r_wen[1]  <= d_rfen && (d_a3 != 5'd0);
            end
            for (int unsigned k = 2; k <= NSTG; k++) begin
                r_a3[k]   <= r_a3[k-1];
                r_tnew[k] <= sat_dec(r_tnew[k-1]);
                r_wen[k]  <= r_wen[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (d_mdstart && !w_stall) begin
            r_md_cnt <= d_mdop ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

endmodule
